// File: rtl/ram2video_scaled_pkg.sv
// Shared configuration for the scaled frame-buffer video reader.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a; the raster free-runs once armed and is never stalled.
package ram2video_scaled_pkg;

  localparam int RGB_W = 24;
  localparam int CNT_W = 12;

  // Sync pulses are active-low in the default 480p timing set.
  localparam logic DEF_HSYNC_POL = 1'b0;
  localparam logic DEF_VSYNC_POL = 1'b0;

  localparam int DEF_H_TOTAL      = 858;
  localparam int DEF_H_VISIBLE    = 720;
  localparam int DEF_H_SYNC_START = 736;
  localparam int DEF_H_SYNC_WIDTH = 62;
  localparam int DEF_V_TOTAL      = 525;
  localparam int DEF_V_TOTAL_ALT  = 526;
  localparam int DEF_V_VISIBLE    = 480;
  localparam int DEF_V_SYNC_START = 489;
  localparam int DEF_V_SYNC_WIDTH = 6;

  // Per-pixel flags that travel alongside the RAM read.
  typedef struct packed {
    logic win;
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } vflags_t;

  localparam int VFLAGS_W = $bits(vflags_t);

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ram2video_scaled_video_pipe_delay.sv
// Fixed-depth shift register aligning raster flags with RAM read data.
// Latency: DEPTH clocks.
// Backpressure: none; shifts every clock, clears on reset.
module ram2video_scaled_video_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift flags one stage per clock; reset discards everything in flight.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= dat_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dat_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ram2video_scaled.sv
// Raster generator that reads a scaled source window from line RAM and drives RGB/sync/DE.
// Latency: RD_LATENCY clocks from rdaddr to the matching pixel on the outputs.
// Backpressure: none; free-running once triggered, any reset returns it to idle.
module ram2video_scaled
  import ram2video_scaled_pkg::*;
#(
  parameter int   H_TOTAL      = DEF_H_TOTAL,
  parameter int   H_VISIBLE    = DEF_H_VISIBLE,
  parameter int   H_SYNC_START = DEF_H_SYNC_START,
  parameter int   H_SYNC_WIDTH = DEF_H_SYNC_WIDTH,
  parameter int   V_TOTAL      = DEF_V_TOTAL,
  parameter int   V_TOTAL_ALT  = DEF_V_TOTAL_ALT,
  parameter int   V_VISIBLE    = DEF_V_VISIBLE,
  parameter int   V_SYNC_START = DEF_V_SYNC_START,
  parameter int   V_SYNC_WIDTH = DEF_V_SYNC_WIDTH,
  parameter int   H_OFFSET     = 40,
  parameter int   V_OFFSET     = 0,
  parameter int   LINE_LEN     = 640,
  parameter int   SRC_LINES    = 240,
  parameter int   ADDR_BITS    = 17,
  parameter int   HREP         = 1,
  parameter int   VREP         = 2,
  parameter int   RD_LATENCY   = 2,
  parameter logic HSYNC_POL    = DEF_HSYNC_POL,
  parameter logic VSYNC_POL    = DEF_VSYNC_POL,
  parameter logic INVERT_CLK   = 1'b0
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 starttrigger_i,
  input  logic                 line_doubler_i,
  input  logic                 add_line_i,
  input  logic [RGB_W-1:0]     rddata_i,
  output logic [ADDR_BITS-1:0] rdaddr_o,
  output logic [7:0]           red_o,
  output logic [7:0]           green_o,
  output logic [7:0]           blue_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 DrawArea_o,
  output logic                 frame_start_o,
  output logic                 running_o,
  output logic                 videoClock_o
);

  localparam int AXW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_ALT = CNT_W'(V_TOTAL_ALT - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG     = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [CNT_W-1:0] VS_BEG     = CNT_W'(V_SYNC_START);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_SYNC_START + V_SYNC_WIDTH);
  // Source window bounds, already clipped to the visible area.
  localparam logic [CNT_W-1:0] H_WIN_BEG  = CNT_W'(H_OFFSET);
  localparam logic [CNT_W-1:0] H_WIN_END  = CNT_W'(imin(H_OFFSET + LINE_LEN * HREP, H_VISIBLE));
  localparam logic [CNT_W-1:0] V_WIN_BEG  = CNT_W'(V_OFFSET);
  localparam logic [CNT_W-1:0] V_WIN_END1 = CNT_W'(imin(V_OFFSET + SRC_LINES, V_VISIBLE));
  localparam logic [CNT_W-1:0] V_WIN_ENDN = CNT_W'(imin(V_OFFSET + SRC_LINES * VREP, V_VISIBLE));
  localparam logic [1:0]       HREP_LAST  = 2'(HREP - 1);
  localparam logic [1:0]       VREP_LAST  = 2'(VREP - 1);
  localparam logic [ADDR_BITS-1:0] LL_A   = ADDR_BITS'(LINE_LEN);
  localparam logic [ADDR_BITS-1:0] Y_MAX  = ADDR_BITS'((SRC_LINES - 1) * LINE_LEN);

  logic                 running_q, running_d;
  logic [CNT_W-1:0]     cx_q, cx_d, cy_q, cy_d;
  logic [AXW-1:0]       addr_x_q, addr_x_d;
  logic [ADDR_BITS-1:0] addr_y_q, addr_y_d;
  logic [1:0]           hrep_cnt_q, hrep_cnt_d, vrep_cnt_q, vrep_cnt_d;
  logic                 ld_q, al_q;

  logic                 edge_rst;
  logic [CNT_W-1:0]     v_last, v_win_end;
  logic [1:0]           vrep_last;
  logic                 line_end, frame_end, h_in, v_in, win0;
  vflags_t              flags0, flags_dly;

  // A change on either mode input restarts the reader from idle.
  assign edge_rst  = (line_doubler_i != ld_q) || (add_line_i != al_q);

  assign v_last    = add_line_i ? V_LAST_ALT : V_LAST;
  assign v_win_end = line_doubler_i ? V_WIN_ENDN : V_WIN_END1;
  assign vrep_last = line_doubler_i ? VREP_LAST : 2'd0;
  assign line_end  = (cx_q == H_LAST);
  assign frame_end = line_end && (cy_q == v_last);
  assign h_in      = (cx_q >= H_WIN_BEG) && (cx_q < H_WIN_END);
  assign v_in      = (cy_q >= V_WIN_BEG) && (cy_q < v_win_end);
  assign win0      = running_q && h_in && v_in;

  assign rdaddr_o  = win0 ? (addr_y_q + ADDR_BITS'(addr_x_q)) : '0;

  // Previous mode input values for change detection.
  always_ff @(posedge clock_i) begin
    ld_q <= line_doubler_i;
    al_q <= add_line_i;
  end

  // Next state of the raster counters and source address generator.
  always_comb begin
    running_d  = running_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    addr_x_d   = addr_x_q;
    addr_y_d   = addr_y_q;
    hrep_cnt_d = hrep_cnt_q;
    vrep_cnt_d = vrep_cnt_q;
    if (edge_rst) begin
      running_d  = 1'b0;
      cx_d       = H_WIN_BEG;
      cy_d       = V_WIN_BEG;
      addr_x_d   = '0;
      addr_y_d   = '0;
      hrep_cnt_d = '0;
      vrep_cnt_d = '0;
    end else if (!running_q) begin
      running_d = starttrigger_i;
    end else begin
      if (line_end) begin
        cx_d = '0;
        cy_d = (cy_q == v_last) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
      if (line_end) begin
        addr_x_d   = '0;
        hrep_cnt_d = '0;
      end else if (win0) begin
        if (hrep_cnt_q == HREP_LAST) begin
          hrep_cnt_d = '0;
          addr_x_d   = addr_x_q + 1'b1;
        end else begin
          hrep_cnt_d = hrep_cnt_q + 1'b1;
        end
      end
      if (frame_end) begin
        addr_y_d   = '0;
        vrep_cnt_d = '0;
      end else if (line_end && v_in) begin
        if (vrep_cnt_q == vrep_last) begin
          vrep_cnt_d = '0;
          // Hold on the last source line rather than running past the buffer.
          if (addr_y_q < Y_MAX) addr_y_d = addr_y_q + LL_A;
        end else begin
          vrep_cnt_d = vrep_cnt_q + 1'b1;
        end
      end
    end
  end

  // Register raster state; external reset parks the reader in idle.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      running_q  <= 1'b0;
      cx_q       <= H_WIN_BEG;
      cy_q       <= V_WIN_BEG;
      addr_x_q   <= '0;
      addr_y_q   <= '0;
      hrep_cnt_q <= '0;
      vrep_cnt_q <= '0;
    end else begin
      running_q  <= running_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      addr_x_q   <= addr_x_d;
      addr_y_q   <= addr_y_d;
      hrep_cnt_q <= hrep_cnt_d;
      vrep_cnt_q <= vrep_cnt_d;
    end
  end

  // Stage-0 flags; vsync edges line up with the hsync leading edge.
  always_comb begin
    flags0     = '0;
    flags0.win = win0;
    flags0.hs  = running_q && (cx_q >= HS_BEG) && (cx_q < HS_END);
    flags0.vs  = running_q && (((cy_q == VS_BEG) && (cx_q >= HS_BEG)) ||
                               ((cy_q > VS_BEG) && (cy_q < VS_END)) ||
                               ((cy_q == VS_END) && (cx_q < HS_BEG)));
    flags0.de  = running_q && (cx_q < H_VIS) && (cy_q < V_VIS);
    flags0.fs  = running_q && (cx_q == '0) && (cy_q == '0);
  end

  ram2video_scaled_video_pipe_delay #(
    .WIDTH (VFLAGS_W),
    .DEPTH (RD_LATENCY)
  ) u_flag_dly (
    .clock_i (clock_i),
    .reset_i (reset_i && !edge_rst),
    .dat_i   (flags0),
    .dat_o   (flags_dly)
  );

  assign {red_o, green_o, blue_o} = flags_dly.win ? rddata_i : '0;
  assign hsync_o       = flags_dly.hs ? HSYNC_POL : ~HSYNC_POL;
  assign vsync_o       = flags_dly.vs ? VSYNC_POL : ~VSYNC_POL;
  assign DrawArea_o    = flags_dly.de;
  assign frame_start_o = flags_dly.fs;
  assign running_o     = running_q;
  assign videoClock_o  = clock_i ^ INVERT_CLK;

endmodule
